// File: rtl/xor_parity_pkg.sv
// xor_parity_pkg: shared state encoding, widths and helpers for the XOR parity link.
package xor_parity_pkg;
    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, BREAK} rx_state_t;
    localparam int STAT_W = 16;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;
    function automatic int cnt_w(input int data_w);
        return $clog2(data_w);
    endfunction
endpackage

// File: rtl/xor_parity_acc.sv
// xor_parity_acc: running XOR accumulator; clear loads the seed, enable folds in one bit.
module xor_parity_acc (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_seed,
    input  logic i_en,
    input  logic i_bit,
    output logic o_acc
);
    logic r_acc;
    always_ff @(posedge clk) begin
        if (!rst_n) r_acc <= 1'b0;
        else if (i_clr) r_acc <= i_seed;
        else if (i_en) r_acc <= r_acc ^ i_bit;
    end
    assign o_acc = r_acc;
endmodule

// File: rtl/xor_parity_rx.sv
// xor_parity_rx: framed serial receiver with parity check and one-entry valid/ready buffer.
// Define PARITY_RX_STATS_EN to build the saturating parity/frame error counters.
module xor_parity_rx
    import xor_parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rx_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_perr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err,
    output logic              overrun,
    output logic [STAT_W-1:0] perr_cnt,
    output logic [STAT_W-1:0] ferr_cnt
);
    localparam int CNT_W = cnt_w(DATA_W);

    rx_state_t         r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift, r_data;
    logic              r_perr, r_valid, r_ferr, r_ovr;
    logic              w_acc, w_acc_clr, w_acc_en, w_done, w_bad_stop, w_last, w_load;

    assign w_last = (r_cnt == CNT_W'(DATA_W - 1));
    assign w_load = w_done && (!r_valid || out_ready);

    always_comb begin
        w_state_nxt = r_state;
        w_acc_clr   = 1'b0;
        w_acc_en    = 1'b0;
        w_done      = 1'b0;
        w_bad_stop  = 1'b0;
        if (bit_en) begin
            case (r_state)
                IDLE:   if (!rx_in) begin w_state_nxt = DATA; w_acc_clr = 1'b1; end
                DATA:   begin w_acc_en = 1'b1; w_state_nxt = w_last ? PARITY : DATA; end
                PARITY: begin w_acc_en = 1'b1; w_state_nxt = STOP; end
                STOP:   begin w_done = rx_in; w_bad_stop = !rx_in; w_state_nxt = rx_in ? IDLE : BREAK; end
                BREAK:  w_state_nxt = rx_in ? IDLE : BREAK;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    xor_parity_acc u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_acc_clr),
        .i_seed (ODD_PARITY),
        .i_en   (w_acc_en),
        .i_bit  (rx_in),
        .o_acc  (w_acc)
    );

    // Right-shifting an LSB-first stream leaves bit i at position i after DATA_W shifts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc_clr) r_cnt <= '0;
            else if (bit_en && r_state == DATA) begin
                r_cnt   <= r_cnt + CNT_W'(1);
                r_shift <= {rx_in, r_shift[DATA_W-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_perr  <= 1'b0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_load) begin
                r_data  <= r_shift;
                r_perr  <= w_acc;
                r_valid <= 1'b1;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
            r_ferr <= w_bad_stop;
            r_ovr  <= w_done && r_valid && !out_ready;
        end
    end

    assign out_data  = r_data;
    assign out_perr  = r_perr;
    assign out_valid = r_valid;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;

`ifdef PARITY_RX_STATS_EN
    logic [STAT_W-1:0] r_perr_cnt, r_ferr_cnt;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perr_cnt <= '0;
            r_ferr_cnt <= '0;
        end else begin
            if (w_load && w_acc && r_perr_cnt != STAT_MAX) r_perr_cnt <= r_perr_cnt + 1'b1;
            if (w_bad_stop && r_ferr_cnt != STAT_MAX) r_ferr_cnt <= r_ferr_cnt + 1'b1;
        end
    end
    assign perr_cnt = r_perr_cnt;
    assign ferr_cnt = r_ferr_cnt;
`else
    assign perr_cnt = '0;
    assign ferr_cnt = '0;
`endif
endmodule

// File: tb/tb_xor_parity_rx.sv
// tb_xor_parity_rx: directed and random frames into even- and odd-parity receivers.
module tb_xor_parity_rx;
`ifdef PARITY_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n, bit_en, rx_in, out_ready;
    logic [7:0]  e_data, o_data;
    logic        e_perr, o_perr, e_valid, o_valid, e_ferr, o_ferr, e_ovr, o_ovr;
    logic [15:0] e_pcnt, o_pcnt, e_fcnt, o_fcnt;
    int checks = 0, failures = 0;
    int n_ferr = 0, n_ovr = 0;
    int m_perr_e = 0, m_perr_o = 0, m_ferr = 0;

    always #5 clk = ~clk;

    xor_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b0)) u_even (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx_in(rx_in),
        .out_data(e_data), .out_perr(e_perr), .out_valid(e_valid), .out_ready(out_ready),
        .frame_err(e_ferr), .overrun(e_ovr), .perr_cnt(e_pcnt), .ferr_cnt(e_fcnt)
    );
    xor_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b1)) u_odd (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx_in(rx_in),
        .out_data(o_data), .out_perr(o_perr), .out_valid(o_valid), .out_ready(out_ready),
        .frame_err(o_ferr), .overrun(o_ovr), .perr_cnt(o_pcnt), .ferr_cnt(o_fcnt)
    );

    always @(negedge clk) begin
        if (e_ferr) n_ferr++;
        if (e_ovr) n_ovr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        rx_in = b;
        bit_en = 1'b0;
        for (int i = 1; i < gap; i++) tick();
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
    endtask

    task automatic send_body(input logic [7:0] d, input logic p, input int gap);
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap);
        send_bit(p, gap);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input int gap);
        send_body(d, p, gap);
        send_bit(stop, gap);
        rx_in = 1'b1;
    endtask

    task automatic check_counters();
        check("perr_cnt_even", e_pcnt, STATS ? m_perr_e : 0);
        check("perr_cnt_odd", o_pcnt, STATS ? m_perr_o : 0);
        check("ferr_cnt_even", e_fcnt, STATS ? m_ferr : 0);
        check("ferr_cnt_odd", o_fcnt, STATS ? m_ferr : 0);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic p);
        logic pe, po;
        pe = (^d) ^ p;
        po = ~((^d) ^ p);
        m_perr_e += int'(pe);
        m_perr_o += int'(po);
        check("valid_even", e_valid, 1);
        check("valid_odd", o_valid, 1);
        check("data_even", e_data, d);
        check("data_odd", o_data, d);
        check("perr_even", e_perr, pe);
        check("perr_odd", o_perr, po);
        check_counters();
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drained_even", e_valid, 0);
        check("drained_odd", o_valid, 0);
    endtask

    task automatic check_reset_state();
        check("rst_valid", {o_valid, e_valid}, 0);
        check("rst_data", {o_data, e_data}, 0);
        check("rst_perr", {o_perr, e_perr}, 0);
        check("rst_ferr", {o_ferr, e_ferr}, 0);
        check("rst_ovr", {o_ovr, e_ovr}, 0);
        check("rst_cnts", {e_pcnt, e_fcnt} | {o_pcnt, o_fcnt}, 0);
    endtask

    initial begin
        logic [7:0] d;
        logic p;
        int gap, ovr0;
        rst_n = 1'b0; bit_en = 1'b0; rx_in = 1'b1; out_ready = 1'b0;
        repeat (3) tick();
        check_reset_state();
        rst_n = 1'b1;
        tick();

        send_body(8'hA5, 1'b0, 1);
        check("no_valid_before_stop", e_valid, 0);
        send_bit(1'b1, 1);
        rx_in = 1'b1;
        expect_frame(8'hA5, 1'b0);
        tick();
        check("valid_holds", e_valid, 1);
        consume();

        send_frame(8'h01, 1'b0, 1'b1, 1);
        expect_frame(8'h01, 1'b0);
        consume();

        send_frame(8'h3C, 1'b0, 1'b0, 1);
        m_ferr++;
        check("ferr_pulse", {o_ferr, e_ferr}, 2'b11);
        check("ferr_no_valid", {o_valid, e_valid}, 0);
        check_counters();
        rx_in = 1'b0;
        tick();
        check("ferr_one_cycle", e_ferr, 0);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1);
        check("break_no_frame", {o_valid, e_valid}, 0);
        send_bit(1'b1, 1);
        send_frame(8'h55, 1'b0, 1'b1, 1);
        expect_frame(8'h55, 1'b0);
        consume();
        check("ferr_count", n_ferr, 1);

        send_frame(8'h11, 1'b0, 1'b1, 1);
        send_frame(8'h22, 1'b0, 1'b1, 1);
        check("overrun_pulse", {o_ovr, e_ovr}, 2'b11);
        tick();
        check("overrun_one_cycle", e_ovr, 0);
        expect_frame(8'h11, 1'b0);
        consume();
        check("overrun_count", n_ovr, 1);

        send_frame(8'h11, 1'b0, 1'b1, 1);
        expect_frame(8'h11, 1'b0);
        send_body(8'h22, 1'b0, 1);
        out_ready = 1'b1;
        send_bit(1'b1, 1);
        out_ready = 1'b0;
        rx_in = 1'b1;
        check("handshake_no_overrun", {o_ovr, e_ovr}, 0);
        expect_frame(8'h22, 1'b0);
        consume();
        check("overrun_count_same", n_ovr, 1);

        send_frame(8'hF0, 1'b0, 1'b1, 4);
        expect_frame(8'hF0, 1'b0);
        consume();

        send_frame(8'h5A, 1'b1, 1'b1, 1);
        expect_frame(8'h5A, 1'b1);
        send_bit(1'b0, 1);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1);
        rst_n = 1'b0;
        tick();
        m_perr_e = 0; m_perr_o = 0; m_ferr = 0;
        check_reset_state();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1);
        repeat (3) tick();
        check("abort_no_valid", {o_valid, e_valid}, 0);
        send_frame(8'h7E, 1'b0, 1'b1, 1);
        expect_frame(8'h7E, 1'b0);
        consume();

        ovr0 = n_ovr;
        for (int n = 0; n < 20; n++) begin
            d = 8'($urandom_range(0, 255));
            p = 1'($urandom_range(0, 1));
            gap = $urandom_range(1, 3);
            send_frame(d, p, 1'b1, gap);
            expect_frame(d, p);
            if (n % 3 == 0) tick();
            consume();
        end
        check("rand_no_overrun", n_ovr, ovr0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/xor_parity_rx.md
Name: xor_parity_rx

Overview:
Receive-side counterpart of the clocked XOR parity generator.
- Deserialises a framed bitstream: start bit, DATA_W data bits LSB first, one parity bit, one stop bit.
- Recomputes parity with a running XOR and flags mismatches.
- Presents each frame through a one-entry valid/ready output buffer.
- Sits between a serial link sampler and byte-wide consumer logic.

Parameters:
DATA_W, 8, data bits per frame (2..32)
ODD_PARITY, 0, 0 = even parity expected (XOR of data and parity bit = 0); 1 = odd (XOR = 1)

Ports:
clk  input  1  single clock, all logic on posedge
rst_n  input  1  reset, synchronous, active-low
bit_en  input  1  rx_in is sampled only on cycles with bit_en=1
rx_in  input  1  serial line; idles at 1
out_data  output  DATA_W  received data word
out_perr  output  1  parity mismatch for the frame in out_data
out_valid  output  1  out_data/out_perr hold a frame
out_ready  input  1  consumer accepts the frame when out_valid&&out_ready
frame_err  output  1  one-cycle pulse: stop bit sampled as 0
overrun  output  1  one-cycle pulse: completed frame dropped because the buffer was full
perr_cnt  output  16  parity error count (see Optional Feature)
ferr_cnt  output  16  frame error count (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at posedge):
  - State goes to IDLE; bit counter and parity accumulator clear.
  - out_data=0, out_perr=0, out_valid=0, frame_err=0, overrun=0, both counters 0.
  - Reset mid-frame discards the partial frame and any buffered frame.
- State machine advances only on bit_en=1 cycles; with bit_en=0 all state holds.
  - IDLE: rx_in=0 -> DATA; counter=0; acc=ODD_PARITY.
  - DATA: shift rx_in into data[cnt]; acc^=rx_in; cnt==DATA_W-1 -> PARITY.
  - PARITY: acc^=rx_in -> STOP.
  - STOP, rx_in=1: frame complete; the frame's perr = acc (nonzero means mismatch) -> IDLE.
  - STOP, rx_in=0: frame_err pulses the next cycle; frame discarded -> BREAK.
  - BREAK: wait for a sampled rx_in=1 -> IDLE. A 0 held at the line never starts a new frame.
- Latency: out_valid rises on the cycle after the posedge that samples a good stop bit.
  - Frames with a parity mismatch are still delivered, with out_perr=1.
- Output buffer:
  - out_valid holds until out_valid&&out_ready at a posedge.
  - out_data and out_perr are stable while out_valid=1.
- Simultaneous events:
  - Frame completes on the same posedge as a handshake: the new frame loads and out_valid stays 1. No overrun.
  - Frame completes while out_valid=1 and out_ready=0: the new frame is dropped, overrun pulses for one cycle, and the buffer keeps the old frame.
- The parity computation is width-exact XOR reduction; no arithmetic widening.

Optional Feature:
PARITY_RX_STATS_EN
- Defined:
  - perr_cnt increments once per delivered frame with perr=1.
  - ferr_cnt increments once per frame_err pulse.
  - Both counters saturate at 16'hFFFF and clear only on reset.
- Undefined: perr_cnt and ferr_cnt are tied to 0 and no counter flops are built.

Decomposition:
- Package xor_parity_pkg:
  - state enum {IDLE, DATA, PARITY, STOP, BREAK}
  - CNT_W = $clog2(DATA_W)
  - STAT_W = 16 and STAT_MAX
- Sub-module xor_parity_acc: running XOR accumulator with clear-to-seed, enable and bit input. It is reusable on the transmit side.

Test Plan (DATA_W=8, bit_en=1 every cycle unless stated):
- Even parity, bits 0, A5 LSB-first, parity 0, stop 1 -> out_valid the cycle after stop; out_data=8'hA5; out_perr=0.
- Even parity, byte 8'h01 with parity bit 0 -> out_data=8'h01, out_perr=1; with stats, perr_cnt=1. With ODD_PARITY=1 the same frame -> out_perr=0.
- Byte 8'h3C with a stop bit of 0 -> frame_err pulses once; no out_valid. rx_in held 0 for 5 bits -> no new frame; then 1 followed by a valid 8'h55 frame -> out_data=8'h55.
- out_ready=0, two back-to-back frames 8'h11 and 8'h22 -> out_data stays 8'h11; overrun pulses once at the second stop. out_ready=1 on the exact completion cycle of 8'h22 instead -> 8'h22 loads, no overrun.
- bit_en=1 only every 4th cycle, frame 8'hF0 -> out_data=8'hF0. State is held on bit_en=0 cycles: no extra shifts.
- rst_n=0 for one cycle after data bit 4 of a frame -> all outputs 0. The trailing bits of the aborted frame must not produce out_valid; the next clean frame 8'h7E is received correctly.
